pmem_write_buffer: RTL and testbench
====================================

# pmem_write_buffer

Line-granular write buffer between the L1 `cache` and physical memory in the LC-3b `mp2` system. Dirty-line writebacks from the cache are acknowledged as soon as they are buffered and drained to physical memory in the background, so a miss's fill read is not serialized behind its eviction. Buffered lines are forwarded on read hits and coalesced on repeat writes, so buffered data is never stale. The cache-facing port uses the same protocol as the physical-memory port, so the block drops in transparently.

## Interface
- `DEPTH`, 2, number of line entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmem_read`  in  1  cache line read request; held until `cmem_resp`.
- `cmem_write`  in  1  cache line writeback request; held until `cmem_resp`.
- `cmem_address`  in  16  `lc3b_pmem_addr`, line address; bits [3:0] ignored.
- `cmem_wdata`  in  128  `lc3b_pmem_line` to write.
- `cmem_rdata`  out  128  registered read data; valid while `cmem_resp`=1.
- `cmem_resp`  out  1  one-cycle completion pulse.
- `pmem_read`, `pmem_write`  out  1  physical memory requests.
- `pmem_address`  out  16  line address to memory; bits [3:0] driven 0.
- `pmem_wdata`  out  128  line to memory.
- `pmem_rdata`  in  128  line from memory; sampled when `pmem_resp`=1.
- `pmem_resp`  in  1  memory completion pulse.

## Operation
- Storage: DEPTH entries {valid, tag[15:4], data[127:0]}, circular FIFO with head/tail pointers and a count (0..DEPTH).
- Requests are sampled only when `cmem_resp`=0; the cache drops its request the cycle after `cmem_resp`. `cmem_read` and `cmem_write` are never both high.
- Write, tag matches valid entry not being drained: overwrite that entry's data in place (coalesce), count unchanged.
- Write, tag matches the entry being drained: stall until that drain completes, then allocate.
- Write, no match, count<DEPTH: write at tail, tail+1 mod DEPTH, count+1.
- Write, no match, full: stall; accept in the cycle after the head pop.
- Read hit (tag matches any valid entry, including the one draining): return buffered data; memory untouched.
- Read miss: goes to memory via the pmem FSM.
- pmem FSM states: PM_IDLE, PM_READ, PM_WRITE.
  - PM_IDLE → PM_READ if a read miss is pending (priority).
  - PM_IDLE → PM_WRITE if count>0 and no read miss is pending.
  - PM_READ: drive `pmem_read`, address = `cmem_address` with [3:0]=0. On `pmem_resp`: latch `pmem_rdata`; → PM_IDLE.
  - PM_WRITE: drive `pmem_write` with the head tag/data. On `pmem_resp`: invalidate head, head+1, count−1; → PM_IDLE.
  - A write in progress is never aborted; a read miss arriving mid-drain waits for it.
- Same-cycle pop and allocate is legal: count unchanged, both pointers advance.
- Reset, asserted at any time including mid-transaction: all entries invalid, pointers and count 0, FSM PM_IDLE, all outputs 0. Any buffered data is lost.

## Timing
- Write accept: `cmem_resp` = 1 the cycle after the accepting edge.
- Read hit: `cmem_rdata`/`cmem_resp` the cycle after the sampling edge.
- Read miss: `pmem_read` rises the cycle after the request is sampled (if PM_IDLE); `cmem_resp` and data the cycle after `pmem_resp`.
- `pmem_read`/`pmem_write` drop the cycle after `pmem_resp`.
- `pmem_*` outputs are registered or decoded from state only; no combinational path from `cmem_*` to `pmem_*`.
- `cmem_resp` is never high for two consecutive cycles.

## Test plan
- Empty buffer; write 0x1230 with line A → `cmem_resp` next cycle. Then `pmem_write` with address 0x1230 and data A until `pmem_resp`; count returns to 0.
- Hold `pmem_resp` low; write 0x1000, 0x2000, 0x3000 (DEPTH=2) → first two acked, third stalls. Assert `pmem_resp` → third acked the cycle after the pop; drain order 0x1000, 0x2000, 0x3000.
- Write 0x4000=A, then write 0x4000=B before the drain starts → count stays 1; memory receives only B.
- Buffer 0x5000=C; read 0x5000 → `cmem_rdata`=C the next cycle; `pmem_read` never asserted.
- Buffer 0x6000 with pmem idle; in the same cycle read miss 0x7000 → `pmem_read` 0x7000 before `pmem_write` 0x6000. Returned line appears on `cmem_rdata` with `cmem_resp` the cycle after `pmem_resp`.
- Pull `rst_n` low mid-PM_WRITE → all outputs 0 immediately; after release, count 0 and a read of the old address goes to memory.

Source files
------------

// File: rtl/pmem_write_buffer_if.sv
// Line-memory bus shared by the cache-facing and memory-facing sides of the
// write buffer. The protocol is the same on both sides:
//   read/write  : request, held by the master until resp
//   address     : line address (bits [3:0] carry no meaning)
//   wdata       : line to write
//   rdata       : line returned, valid while resp is high
//   resp        : one-cycle completion pulse from the slave
// master drives the request side; slave drives rdata/resp.
interface pmem_write_buffer_if;
  logic         read;
  logic         write;
  logic [15:0]  address;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic         resp;

  modport master (output read, write, address, wdata, input rdata, resp);
  modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/pmem_write_buffer.sv
// Line-granular write buffer between the L1 cache and physical memory.
// Writebacks are acknowledged once buffered and drained in FIFO order in the
// background; reads that hit a buffered line are served from the buffer, and
// repeat writes to a buffered line coalesce in place.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cmem       : cache-facing bus (slave)
//   pmem       : physical-memory bus (master); all outputs come from
//                registers, never combinationally from cmem
module pmem_write_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pmem_write_buffer_if.slave  cmem,
  pmem_write_buffer_if.master pmem
);
  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {PM_IDLE = 2'd0, PM_READ = 2'd1, PM_WRITE = 2'd2} pm_state_e;

  pm_state_e                r_state;
  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0][11:0]   r_tag;
  logic [DEPTH-1:0][127:0]  r_data;
  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [PW:0]              r_count;
  logic                     r_cresp;
  logic [127:0]             r_crdata;
  logic                     r_pread;
  logic                     r_pwrite;
  logic [15:0]              r_paddr;

  logic [11:0]   w_tag;
  logic          w_hit;
  logic [PW-1:0] w_hit_idx;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drain_hit;
  logic          w_coalesce;
  logic          w_alloc;
  logic          w_rd;
  logic          w_rd_hit;
  logic          w_rd_miss;
  logic          w_unused;

  assign w_tag    = cmem.address[15:4];
  assign w_unused = ^cmem.address[3:0];

  // Tags are unique among valid entries: allocation only happens on a miss.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_tag[i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = PW'(i);
      end
    end
  end

  assign w_full      = (r_count == CNT_FULL);
  assign w_pop       = (r_state == PM_WRITE) && pmem.resp;
  // A request is only looked at while no response is outstanding.
  assign w_wr        = cmem.write && !r_cresp;
  // The line on the memory bus must not change under the drain; a write to it
  // waits for the pop and then allocates a fresh entry.
  assign w_drain_hit = (r_state == PM_WRITE) && (w_hit_idx == r_head);
  assign w_coalesce  = w_wr && w_hit && !w_drain_hit;
  assign w_alloc     = w_wr && !w_hit && !w_full;
  // While PM_READ is active the read request on cmem is the one being serviced.
  assign w_rd        = cmem.read && !r_cresp && (r_state != PM_READ);
  assign w_rd_hit    = w_rd && w_hit;
  assign w_rd_miss   = w_rd && !w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= PM_IDLE;
      r_valid  <= '0;
      r_tag    <= '0;
      r_data   <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_cresp  <= 1'b0;
      r_crdata <= '0;
      r_pread  <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
    end else begin
      r_cresp <= 1'b0;

      if (w_coalesce) begin
        r_data[w_hit_idx] <= cmem.wdata;
        r_cresp           <= 1'b1;
      end

      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tag[r_tail]   <= w_tag;
        r_data[r_tail]  <= cmem.wdata;
        r_tail          <= r_tail + 1'b1;
        r_cresp         <= 1'b1;
      end

      if (w_rd_hit) begin
        r_crdata <= r_data[w_hit_idx];
        r_cresp  <= 1'b1;
      end

      // Tail never equals head while a pop and an allocate coincide
      // (that needs 0 < count < DEPTH), so these slot writes cannot collide.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end

      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        PM_IDLE: begin
          if (w_rd_miss) begin
            r_state <= PM_READ;
            r_pread <= 1'b1;
            r_paddr <= {w_tag, 4'h0};
          end else if (r_count != '0) begin
            r_state  <= PM_WRITE;
            r_pwrite <= 1'b1;
            r_paddr  <= {r_tag[r_head], 4'h0};
          end
        end
        PM_READ: begin
          if (pmem.resp) begin
            r_state  <= PM_IDLE;
            r_pread  <= 1'b0;
            r_paddr  <= '0;
            r_crdata <= pmem.rdata;
            r_cresp  <= 1'b1;
          end
        end
        PM_WRITE: begin
          if (pmem.resp) begin
            r_state  <= PM_IDLE;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
          end
        end
        default: begin
          r_state  <= PM_IDLE;
          r_pread  <= 1'b0;
          r_pwrite <= 1'b0;
          r_paddr  <= '0;
        end
      endcase
    end
  end

  assign cmem.resp    = r_cresp;
  assign cmem.rdata   = r_crdata;
  assign pmem.read    = r_pread;
  assign pmem.write   = r_pwrite;
  assign pmem.address = r_paddr;
  // Head entry is frozen for the whole drain, so the registered data is stable.
  assign pmem.wdata   = r_pwrite ? r_data[r_head] : '0;
endmodule

// File: tb/tb_pmem_write_buffer.sv
// Bench for pmem_write_buffer: directed scenarios followed by a randomized
// read/write mix checked against an architectural memory model (last value
// written per line) and a behavioural physical memory.
module tb_pmem_write_buffer;
  localparam int BUDGET = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_write_buffer_if cmem ();
  pmem_write_buffer_if pmem ();

  pmem_write_buffer #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmem  (cmem),
    .pmem  (pmem)
  );

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
    int           cyc;    // cycle in which resp was driven
    int           start;  // cycle in which the request was first seen
  } op_t;

  op_t          oplog [$];
  logic [127:0] arch  [logic [15:0]];
  logic [127:0] pm    [logic [15:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dbl = 0;
  logic prev_resp = 1'b0;
  bit hold = 1'b1;
  bit rand_lat = 1'b0;
  int last_ack_cyc = 0;
  int last_issue_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmem.resp && prev_resp) dbl <= dbl + 1;
    prev_resp <= cmem.resp;
  end

  function automatic logic [127:0] init_line(input logic [15:0] a);
    return {8{a ^ 16'h5A5A}};
  endfunction

  function automatic logic [127:0] model_rd(input logic [15:0] a);
    logic [15:0] l;
    l = a & 16'hFFF0;
    return arch.exists(l) ? arch[l] : init_line(l);
  endfunction

  function automatic logic [127:0] pm_rd(input logic [15:0] a);
    logic [15:0] l;
    l = a & 16'hFFF0;
    return pm.exists(l) ? pm[l] : init_line(l);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Physical memory: responds lat cycles after a request is seen unless held.
  initial begin : responder
    int cnt;
    int lat;
    int st;
    bit busy;
    cnt = 0; lat = 2; st = 0; busy = 1'b0;
    pmem.resp = 1'b0;
    pmem.rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; cnt = 0; pmem.resp = 1'b0;
      end else if (pmem.resp) begin
        pmem.resp = 1'b0; busy = 1'b0; cnt = 0;
      end else if (pmem.read || pmem.write) begin
        if (!busy) begin
          busy = 1'b1; cnt = 0; st = cyc;
          lat = rand_lat ? int'($urandom_range(1, 4)) : 2;
        end
        if (!hold) cnt++;
        if (cnt >= lat) begin
          if (pmem.write) begin
            pm[pmem.address & 16'hFFF0] = pmem.wdata;
            oplog.push_back('{1'b1, pmem.address, pmem.wdata, cyc, st});
          end else begin
            pmem.rdata = pm_rd(pmem.address);
            oplog.push_back('{1'b0, pmem.address, pmem.rdata, cyc, st});
          end
          pmem.resp = 1'b1;
        end
      end
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [127:0] d, output int n);
    n = 0;
    last_issue_cyc = cyc;
    cmem.address = a; cmem.wdata = d; cmem.write = 1'b1;
    while (!cmem.resp && n < BUDGET) begin @(negedge clk); n++; end
    chk("wr_ack", 128'(cmem.resp), 128'(1'b1));
    if (cmem.resp) arch[a & 16'hFFF0] = d;
    last_ack_cyc = cyc;
    cmem.write = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, output logic [127:0] d, output int n);
    n = 0;
    last_issue_cyc = cyc;
    cmem.address = a; cmem.read = 1'b1;
    while (!cmem.resp && n < BUDGET) begin @(negedge clk); n++; end
    chk("rd_ack", 128'(cmem.resp), 128'(1'b1));
    d = cmem.rdata;
    last_ack_cyc = cyc;
    cmem.read = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ops(input int target);
    int k;
    k = 0;
    while (oplog.size() < target && k < BUDGET) begin @(negedge clk); k++; end
    chk("oplog_wait", 128'(oplog.size()), 128'(target));
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_cresp"},  128'(cmem.resp),    '0);
    chk({tag, "_crdata"}, cmem.rdata,         '0);
    chk({tag, "_pread"},  128'(pmem.read),    '0);
    chk({tag, "_pwrite"}, 128'(pmem.write),   '0);
    chk({tag, "_paddr"},  128'(pmem.address), '0);
    chk({tag, "_pwdata"}, pmem.wdata,         '0);
  endtask

  initial begin : main
    int n, n3, b, nrd;
    logic [127:0] d, e;
    logic [15:0] a;
    cmem.read = 1'b0; cmem.write = 1'b0; cmem.address = '0; cmem.wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_outs_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single writeback: immediate ack, then drained with the same line
    hold = 1'b1; b = oplog.size();
    do_write(16'h1230, {4{32'hAAAA_0001}}, n);
    chk("t1_wr_lat", 128'(n), 128'(1));
    chk("t1_pwrite", 128'(pmem.write), 128'(1'b1));
    chk("t1_paddr", 128'(pmem.address), 128'(16'h1230));
    chk("t1_pwdata", pmem.wdata, {4{32'hAAAA_0001}});
    hold = 1'b0;
    wait_ops(b + 1);
    chk("t1_drain_addr", 128'(oplog[b].addr), 128'(16'h1230));
    chk("t1_drain_data", oplog[b].data, {4{32'hAAAA_0001}});
    repeat (6) @(negedge clk);
    chk("t1_idle_pwrite", 128'(pmem.write), '0);
    chk("t1_one_drain", 128'(oplog.size()), 128'(b + 1));

    // Full buffer: third write stalls until the cycle after the head pop
    hold = 1'b1; b = oplog.size();
    do_write(16'h1000, {4{32'h1111_0000}}, n);
    chk("t2_wr1_lat", 128'(n), 128'(1));
    do_write(16'h2000, {4{32'h2222_0000}}, n);
    chk("t2_wr2_lat", 128'(n), 128'(1));
    fork
      do_write(16'h3000, {4{32'h3333_0000}}, n3);
      begin repeat (6) @(negedge clk); hold = 1'b0; end
    join
    chk("t2_wr3_stalled", 128'(n3 > 1), 128'(1'b1));
    wait_ops(b + 3);
    chk("t2_ack_after_pop", 128'(last_ack_cyc), 128'(oplog[b].cyc + 2));
    chk("t2_order0", 128'(oplog[b].addr),     128'(16'h1000));
    chk("t2_order1", 128'(oplog[b + 1].addr), 128'(16'h2000));
    chk("t2_order2", 128'(oplog[b + 2].addr), 128'(16'h3000));
    chk("t2_data2",  oplog[b + 2].data, {4{32'h3333_0000}});
    repeat (6) @(negedge clk);

    // Coalesce: second write to a buffered, non-draining line needs no slot
    hold = 1'b1; b = oplog.size();
    do_write(16'h8000, {4{32'h8888_0000}}, n);
    do_write(16'h4000, {4{32'hAAAA_4000}}, n);
    do_write(16'h4000, {4{32'hBBBB_4000}}, n);
    chk("t3_coalesce_lat", 128'(n), 128'(1));
    hold = 1'b0;
    wait_ops(b + 2);
    repeat (10) @(negedge clk);
    chk("t3_drain_count", 128'(oplog.size()), 128'(b + 2));
    chk("t3_drain_addr", 128'(oplog[b + 1].addr), 128'(16'h4000));
    chk("t3_drain_data", oplog[b + 1].data, {4{32'hBBBB_4000}});

    // Write to the line currently draining waits, then allocates again
    hold = 1'b1; b = oplog.size();
    do_write(16'h9000, {4{32'h9999_0001}}, n);
    fork
      do_write(16'h9000, {4{32'h9999_0002}}, n3);
      begin repeat (5) @(negedge clk); hold = 1'b0; end
    join
    chk("t3b_stalled", 128'(n3 > 1), 128'(1'b1));
    wait_ops(b + 2);
    chk("t3b_first",  oplog[b].data,     {4{32'h9999_0001}});
    chk("t3b_second", oplog[b + 1].data, {4{32'h9999_0002}});
    repeat (6) @(negedge clk);

    // Read hits on the draining entry and on a queued entry
    hold = 1'b1; b = oplog.size();
    do_write(16'h5000, {4{32'hCCCC_5000}}, n);
    do_read(16'h5000, d, n);
    chk("t4_hit_lat", 128'(n), 128'(1));
    chk("t4_hit_data", d, model_rd(16'h5000));
    do_write(16'h5100, {4{32'hCCCC_5100}}, n);
    do_read(16'h5104, d, n);
    chk("t4_hit2_lat", 128'(n), 128'(1));
    chk("t4_hit2_data", d, model_rd(16'h5104));
    hold = 1'b0;
    wait_ops(b + 2);
    repeat (6) @(negedge clk);
    nrd = 0;
    for (int i = b; i < oplog.size(); i++) if (!oplog[i].wr) nrd++;
    chk("t4_no_pread", 128'(nrd), '0);

    // Read miss pending when the FSM returns to idle beats a queued drain
    hold = 1'b1; b = oplog.size();
    do_write(16'h6100, {4{32'h6666_0100}}, n);
    do_write(16'h6000, {4{32'h6666_0000}}, n);
    fork
      do_read(16'h7005, d, n);
      begin repeat (4) @(negedge clk); hold = 1'b0; end
    join
    wait_ops(b + 3);
    chk("t5_op0", {oplog[b].wr, oplog[b].addr},         {1'b1, 16'h6100});
    chk("t5_op1", {oplog[b + 1].wr, oplog[b + 1].addr}, {1'b0, 16'h7000});
    chk("t5_op2", {oplog[b + 2].wr, oplog[b + 2].addr}, {1'b1, 16'h6000});
    chk("t5_rdata", d, model_rd(16'h7005));
    chk("t5_resp_timing", 128'(last_ack_cyc), 128'(oplog[b + 1].cyc + 1));
    repeat (8) @(negedge clk);

    // Read miss on an idle FSM: pmem_read the cycle after sampling
    b = oplog.size();
    do_read(16'h7800, d, n);
    wait_ops(b + 1);
    chk("t5b_pread_start", 128'(oplog[b].start), 128'(last_issue_cyc + 1));
    chk("t5b_resp_timing", 128'(last_ack_cyc), 128'(oplog[b].cyc + 1));
    chk("t5b_rdata", d, model_rd(16'h7800));
    repeat (4) @(negedge clk);

    // Reset in the middle of a drain loses the buffered line
    hold = 1'b1;
    do_write(16'hA000, {4{32'hEEEE_A000}}, n);
    chk("t6_pre_pwrite", 128'(pmem.write), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    chk_outs_zero("t6_rst");
    arch.delete(16'hA000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    @(negedge clk);
    b = oplog.size();
    do_read(16'hA000, d, n);
    chk("t6_rdata", d, model_rd(16'hA000));
    wait_ops(b + 1);
    chk("t6_read_to_mem", {oplog[b].wr, oplog[b].addr}, {1'b0, 16'hA000});
    repeat (10) @(negedge clk);
    chk("t6_no_drain", 128'(oplog.size()), 128'(b + 1));

    // Randomized mix over a handful of lines
    rand_lat = 1'b1;
    for (int k = 0; k < 200; k++) begin
      a = 16'hB000 + 16'($urandom_range(0, 5) << 4) + 16'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 55) begin
        do_write(a, {$urandom, $urandom, $urandom, $urandom}, n);
      end else begin
        e = model_rd(a);
        do_read(a, d, n);
        chk("rnd_rdata", d, e);
      end
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      a = 16'hB000 + 16'(i << 4);
      chk("rnd_mem_final", pm_rd(a), model_rd(a));
    end
    chk("quiet_pwrite", 128'(pmem.write), '0);
    chk("no_double_resp", 128'(dbl), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
